// File: rtl/conway_sequencer.sv
// Generation controller for the Life cell array: drives the shared cell rst/ena lines,
// loads the seed, then steps generations on demand or at a programmable free-run rate.
module conway_sequencer #(
  parameter int unsigned PERIOD_W    = 24,
  parameter int unsigned GEN_W       = 16,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_run,
  input  logic                cmd_step,
  input  logic                cmd_clear,
  input  logic [PERIOD_W-1:0] period,
  input  logic                frame_busy,
  output logic                cell_rst,
  output logic                cell_ena,
  output logic [GEN_W-1:0]    generation,
  output logic                gen_wrap,
  output logic [2:0]          seq_state
);

  localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [InitW-1:0] InitLast = InitW'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StIdle  = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StPulse = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [InitW-1:0]    init_cnt_q, init_cnt_d;
  logic [PERIOD_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic                gen_wrap_q, gen_wrap_d;
  logic                cell_rst_q, cell_ena_q;
  logic [PERIOD_W-1:0] wait_last;
  logic                wait_done;

  // A zero period behaves as one wait cycle.
  assign wait_last = (period == '0) ? '0 : period - PERIOD_W'(1);
  // ">=" so a live decrease below the current count still advances promptly.
  assign wait_done = (wait_cnt_q >= wait_last);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    gen_d      = gen_q;
    gen_wrap_d = 1'b0;
    case (state_q)
      StInit: begin
        gen_d = '0;
        if (init_cnt_q == InitLast) begin
          state_d    = StIdle;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + InitW'(1);
        end
      end
      StIdle: begin
        if (cmd_clear) begin
          state_d    = StInit;
          init_cnt_d = '0;
          gen_d      = '0;
        end else if (cmd_step) begin
          state_d = frame_busy ? StHold : StPulse;
        end else if (cmd_run) begin
          state_d    = StWait;
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        if (cmd_clear) begin
          state_d    = StInit;
          init_cnt_d = '0;
          gen_d      = '0;
        end else if (!cmd_run) begin
          state_d = StIdle;
        end else if (cmd_step || wait_done) begin
          state_d = frame_busy ? StHold : StPulse;
        end else begin
          wait_cnt_d = wait_cnt_q + PERIOD_W'(1);
        end
      end
      StHold: begin
        if (cmd_clear) begin
          state_d    = StInit;
          init_cnt_d = '0;
          gen_d      = '0;
        end else if (!frame_busy) begin
          state_d = StPulse;
        end
      end
      StPulse: begin
        // Clear is not accepted here; the requester retries.
        gen_d      = gen_q + GEN_W'(1);
        gen_wrap_d = &gen_q;
        if (cmd_run) begin
          state_d    = StWait;
          wait_cnt_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d    = StInit;
        init_cnt_d = '0;
        gen_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      gen_q      <= '0;
      gen_wrap_q <= 1'b0;
      cell_rst_q <= 1'b1;
      cell_ena_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      gen_q      <= gen_d;
      gen_wrap_q <= gen_wrap_d;
      cell_rst_q <= (state_d == StInit);
      cell_ena_q <= (state_d == StPulse);
    end
  end

  assign cell_rst   = cell_rst_q;
  assign cell_ena   = cell_ena_q;
  assign generation = gen_q;
  assign gen_wrap   = gen_wrap_q;
  assign seq_state  = state_q;

endmodule
